// File: rtl/i2s_rx.sv
// Philips I2S receiver: oversamples sclk/ws/data with clk, frames left/right slots and
// presents each complete left/right pair together with a single-cycle vld strobe.
module i2s_rx #(
    parameter int unsigned DATA_W = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              I2S_sclk,
    input  logic              I2S_ws,
    input  logic              I2S_data,
    output logic [DATA_W-1:0] lft_chnnl,
    output logic [DATA_W-1:0] rght_chnnl,
    output logic              vld
);

    localparam int unsigned CntW = $clog2(DATA_W + 1);
    localparam logic [CntW-1:0] LastBit = CntW'(DATA_W - 1);

    typedef enum logic [2:0] {
        StSync,
        StLft,
        StWaitR,
        StRght,
        StWaitL
    } state_e;

    logic sclk_ff1, sclk_ff2, sclk_ff3;
    logic ws_ff1, ws_ff2;
    logic data_ff1, data_ff2;

    state_e            state_q, state_d;
    logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] lft_hold_q, lft_hold_d;
    logic [DATA_W-1:0] lft_q, lft_d;
    logic [DATA_W-1:0] rght_q, rght_d;
    logic              vld_q, vld_d;
    logic              ws_last_q, ws_last_d;

    logic              sclk_rise, ws_fall, ws_rise;
    logic [DATA_W-1:0] shifted;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_ff1 <= 1'b0;
            sclk_ff2 <= 1'b0;
            sclk_ff3 <= 1'b0;
            ws_ff1   <= 1'b0;
            ws_ff2   <= 1'b0;
            data_ff1 <= 1'b0;
            data_ff2 <= 1'b0;
        end else begin
            sclk_ff1 <= I2S_sclk;
            sclk_ff2 <= sclk_ff1;
            sclk_ff3 <= sclk_ff2;
            ws_ff1   <= I2S_ws;
            ws_ff2   <= ws_ff1;
            data_ff1 <= I2S_data;
            data_ff2 <= data_ff1;
        end
    end

    assign sclk_rise = sclk_ff2 & ~sclk_ff3;
    assign ws_fall   = ~ws_ff2 & ws_last_q;
    assign ws_rise   = ws_ff2 & ~ws_last_q;
    assign shifted   = {shift_q[DATA_W-2:0], data_ff2};

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        lft_hold_d = lft_hold_q;
        lft_d      = lft_q;
        rght_d     = rght_q;
        vld_d      = 1'b0;
        ws_last_d  = ws_last_q;
        if (sclk_rise) begin
            ws_last_d = ws_ff2;
            unique case (state_q)
                StSync: begin
                    if (ws_fall) begin
                        state_d   = StLft;
                        bit_cnt_d = '0;
                    end
                end
                StLft: begin
                    // WS toggling before a full word means a short slot: drop the frame.
                    if (ws_ff2) begin
                        state_d = StSync;
                    end else begin
                        shift_d   = shifted;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == LastBit) begin
                            lft_hold_d = shifted;
                            state_d    = StWaitR;
                        end
                    end
                end
                StWaitR: begin
                    if (ws_rise) begin
                        state_d   = StRght;
                        bit_cnt_d = '0;
                    end else if (ws_fall) begin
                        state_d = StSync;
                    end
                end
                StRght: begin
                    if (!ws_ff2) begin
                        state_d = StSync;
                    end else begin
                        shift_d   = shifted;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == LastBit) begin
                            lft_d   = lft_hold_q;
                            rght_d  = shifted;
                            vld_d   = 1'b1;
                            state_d = StWaitL;
                        end
                    end
                end
                StWaitL: begin
                    if (ws_fall) begin
                        state_d   = StLft;
                        bit_cnt_d = '0;
                    end else if (ws_rise) begin
                        state_d = StSync;
                    end
                end
                default: state_d = StSync;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StSync;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            lft_hold_q <= '0;
            lft_q      <= '0;
            rght_q     <= '0;
            vld_q      <= 1'b0;
            ws_last_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            lft_hold_q <= lft_hold_d;
            lft_q      <= lft_d;
            rght_q     <= rght_d;
            vld_q      <= vld_d;
            ws_last_q  <= ws_last_d;
        end
    end

    assign lft_chnnl  = lft_q;
    assign rght_chnnl = rght_q;
    assign vld        = vld_q;

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: drives Philips I2S frames at sclk = clk/32 and checks the
// latched pairs, vld count and timing against hand-computed values.
module tb_i2s_rx;

    localparam int W = 24;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         I2S_sclk = 1'b0;
    logic         I2S_ws = 1'b0;
    logic         I2S_data = 1'b0;
    logic [W-1:0] lft_chnnl;
    logic [W-1:0] rght_chnnl;
    logic         vld;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int vld_cnt = 0;
    int last_vld_cyc = 0;
    int prev_vld_cyc = 0;
    int rise_cyc = 0;
    int lsb_rise_cyc = 0;
    int base_cnt = 0;

    i2s_rx #(.DATA_W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .I2S_sclk   (I2S_sclk),
        .I2S_ws     (I2S_ws),
        .I2S_data   (I2S_data),
        .lft_chnnl  (lft_chnnl),
        .rght_chnnl (rght_chnnl),
        .vld        (vld)
    );

    always #5 clk = ~clk;

    // Counts vld-high cycles, sampled 1 time unit after each rising edge.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (vld) begin
            vld_cnt      = vld_cnt + 1;
            prev_vld_cyc = last_vld_cyc;
            last_vld_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One sclk period: low half drives ws/data, rising edge mid-way, 16 clk each phase.
    task automatic drive_bit(input logic w, input logic d);
        @(negedge clk);
        I2S_sclk = 1'b0;
        I2S_ws   = w;
        I2S_data = d;
        repeat (16) @(negedge clk);
        I2S_sclk = 1'b1;
        rise_cyc = cyc;
        repeat (15) @(negedge clk);
    endtask

    // Bit 0 is the boundary (pad) bit, bits 1..24 carry MSB..LSB, the rest are pad ones.
    task automatic send_slot(input logic w, input logic [W-1:0] word, input int nbits);
        logic d;
        for (int i = 0; i < nbits; i++) begin
            if (i >= 1 && i <= W) d = word[W-i];
            else d = 1'b1;
            drive_bit(w, d);
            if (i == W) lsb_rise_cyc = rise_cyc;
        end
    endtask

    task automatic send_frame(input logic [W-1:0] l, input logic [W-1:0] r, input int nbits);
        send_slot(1'b0, l, nbits);
        send_slot(1'b1, r, nbits);
    endtask

    initial begin
        // Reset state
        repeat (5) @(posedge clk);
        #1;
        check("reset_lft", 32'(lft_chnnl), 32'h0);
        check("reset_rght", 32'(rght_chnnl), 32'h0);
        check("reset_vld", 32'(vld), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Nominal frame, 25-bit slots
        send_frame(24'hA5A5A5, 24'h123456, 25);
        check("nom_vld_cnt", 32'(vld_cnt), 32'd1);
        check("nom_lft", 32'(lft_chnnl), 32'hA5A5A5);
        check("nom_rght", 32'(rght_chnnl), 32'h123456);
        check("nom_vld_latency", 32'(last_vld_cyc), 32'(lsb_rise_cyc + 3));
        check("nom_vld_low", 32'(vld), 32'h0);

        // Back-to-back 32-bit slots
        send_frame(24'h7FFFFF, 24'h800000, 32);
        check("b2b1_vld_cnt", 32'(vld_cnt), 32'd2);
        check("b2b1_lft", 32'(lft_chnnl), 32'h7FFFFF);
        check("b2b1_rght", 32'(rght_chnnl), 32'h800000);
        send_frame(24'h000001, 24'hFFFFFF, 32);
        check("b2b2_vld_cnt", 32'(vld_cnt), 32'd3);
        check("b2b2_lft", 32'(lft_chnnl), 32'h000001);
        check("b2b2_rght", 32'(rght_chnnl), 32'hFFFFFF);
        check("b2b_spacing", 32'(last_vld_cyc - prev_vld_cyc), 32'd2048);

        // Start mid-right slot after reset
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        base_cnt = vld_cnt;
        for (int i = 0; i < 10; i++) drive_bit(1'b1, i[0]);
        check("mid_no_vld", 32'(vld_cnt), 32'(base_cnt));
        check("mid_lft_zero", 32'(lft_chnnl), 32'h0);
        send_frame(24'h3C3C3C, 24'hC3C3C3, 25);
        check("mid_vld_cnt", 32'(vld_cnt), 32'(base_cnt + 1));
        check("mid_lft", 32'(lft_chnnl), 32'h3C3C3C);
        check("mid_rght", 32'(rght_chnnl), 32'hC3C3C3);

        // Short left slot: only 20 data bits before ws rises
        send_slot(1'b0, 24'hFFFFFF, 21);
        send_slot(1'b1, 24'hAAAAAA, 25);
        check("short_no_vld", 32'(vld_cnt), 32'(base_cnt + 1));
        check("short_hold_lft", 32'(lft_chnnl), 32'h3C3C3C);
        check("short_hold_rght", 32'(rght_chnnl), 32'hC3C3C3);
        send_frame(24'h00F00F, 24'h0FF0F0, 25);
        check("short_next_cnt", 32'(vld_cnt), 32'(base_cnt + 2));
        check("short_next_lft", 32'(lft_chnnl), 32'h00F00F);
        check("short_next_rght", 32'(rght_chnnl), 32'h0FF0F0);

        // Reset during the 12th right bit
        base_cnt = vld_cnt;
        send_slot(1'b0, 24'h111111, 25);
        send_slot(1'b1, 24'h222222, 12);
        @(negedge clk);
        I2S_sclk = 1'b0;
        I2S_ws   = 1'b1;
        I2S_data = 1'b0;
        repeat (16) @(negedge clk);
        I2S_sclk = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst_mid_lft", 32'(lft_chnnl), 32'h0);
        check("rst_mid_rght", 32'(rght_chnnl), 32'h0);
        check("rst_mid_vld", 32'(vld), 32'h0);
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("rst_mid_no_vld", 32'(vld_cnt), 32'(base_cnt));
        send_frame(24'h654321, 24'hFEDCBA, 25);
        check("rst_next_cnt", 32'(vld_cnt), 32'(base_cnt + 1));
        check("rst_next_lft", 32'(lft_chnnl), 32'h654321);
        check("rst_next_rght", 32'(rght_chnnl), 32'hFEDCBA);
        check("rst_next_latency", 32'(last_vld_cyc), 32'(lsb_rise_cyc + 3));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
